// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver with glitch filter, frame checker and
// make/break scan-code decoder producing a held "current key" code.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] character,
    output logic       char_valid,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // synchronizers
    logic clk_s1_q, clk_s2_q;
    logic dat_s1_q, dat_s2_q;

    // clock filter
    logic          flt_q, flt_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          bit_ev;

    // receive FSM
    logic [1:0]    state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rxb_q, rxb_d;
    logic          strobe_q, strobe_d;
    logic          err_q, err_d;

    // key decoder
    logic [7:0]    char_q, char_d;
    logic          cv_q, cv_d;
    logic          brk_q, brk_d;

    // Bring both raw PS/2 lines into the system clock domain.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered level flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        flt_d     = flt_q;
        flt_cnt_d = '0;
        if (clk_s2_q != flt_q) begin
            if (flt_cnt_q == FLT_LAST) begin
                flt_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    // A bit is taken in the same cycle the filtered clock commits to low.
    assign bit_ev = flt_q & ~flt_d;

    // Filter state registers.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            flt_q     <= 1'b1;
            flt_cnt_q <= '0;
        end else begin
            flt_q     <= flt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    // Frame FSM: start, 8 data LSB first, odd parity, stop, with timeout.
    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        rxb_d    = rxb_q;
        strobe_d = 1'b0;
        err_d    = 1'b0;

        if (state_q == S_IDLE || bit_ev) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bit_ev && !dat_s2_q) begin
                    state_d = S_DATA;
                    bcnt_d  = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_ev) begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (bit_ev) begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_ev) begin
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        rxb_d    = shift_q;
                        strobe_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A stalled frame is dropped; a real bit in the same cycle wins.
        if (state_q != S_IDLE && !bit_ev && tmo_q == TMO_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
    end

    // Frame FSM registers.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            bcnt_q   <= 3'd0;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            rxb_q    <= 8'h00;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            rxb_q    <= rxb_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
        end
    end

    // Make/break tracking; E0 prefixes are transparent, F0 arms a release.
    always_comb begin
        char_d = char_q;
        brk_d  = brk_q;
        cv_d   = 1'b0;
        if (strobe_q) begin
            if (rxb_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (rxb_q != 8'hE0) begin
                if (brk_q) begin
                    brk_d = 1'b0;
                    if (rxb_q == char_q) begin
                        char_d = 8'h00;
                        cv_d   = (char_q != 8'h00);
                    end
                end else if (rxb_q != char_q) begin
                    char_d = rxb_q;
                    cv_d   = 1'b1;
                end
            end
        end
    end

    // Decoder registers.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            char_q <= 8'h00;
            brk_q  <= 1'b0;
            cv_q   <= 1'b0;
        end else begin
            char_q <= char_d;
            brk_q  <= brk_d;
            cv_q   <= cv_d;
        end
    end

    assign character  = char_q;
    assign char_valid = cv_q;
    assign rx_byte    = rxb_q;
    assign rx_strobe  = strobe_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized bench for ps2_key_decoder against a byte-level
// keyboard model; PS/2 clock sped up so frames fit the cycle budget.
module tb_ps2_key_decoder;

    localparam int H   = 40;
    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [7:0] character;
    logic       char_valid;
    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_100MHz(clk),
        .reset     (rst_n),
        .ps2clk    (ps2c),
        .ps2data   (ps2d),
        .character (character),
        .char_valid(char_valid),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .frame_err (frame_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // pulse monitor
    int cyc = 0;
    int m_s = 0, m_e = 0, m_cv = 0;
    int last_s = -10;
    int bad_consec = 0, bad_lag = 0;
    logic p_s = 0, p_e = 0, p_c = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rx_strobe) begin
            m_s    <= m_s + 1;
            last_s <= cyc;
        end
        if (frame_err) m_e <= m_e + 1;
        if (char_valid) begin
            m_cv <= m_cv + 1;
            if (cyc - last_s != 1) bad_lag <= bad_lag + 1;
        end
        if ((rx_strobe && p_s) || (frame_err && p_e) ||
            (char_valid && p_c))
            bad_consec <= bad_consec + 1;
        p_s <= rx_strobe;
        p_e <= frame_err;
        p_c <= char_valid;
    end

    // keyboard reference model
    logic [7:0] e_ch = 8'h00, e_rxb = 8'h00;
    bit         e_brk = 0;
    int         e_s = 0, e_e = 0, e_cv = 0;

    task automatic model_byte(input logic [7:0] b, input bit ok);
        logic [7:0] nxt;
        if (!ok) begin
            e_e++;
            return;
        end
        e_s++;
        e_rxb = b;
        nxt = e_ch;
        if (b == 8'hF0) e_brk = 1;
        else if (b == 8'hE0) nxt = e_ch;
        else if (e_brk) begin
            e_brk = 0;
            if (b == e_ch) nxt = 8'h00;
        end else nxt = b;
        if (nxt != e_ch) e_cv++;
        e_ch = nxt;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic glitch();
        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par,
                        input bit bad_stop, input int nbits,
                        input bit glt);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = f[i];
            wait_cyc(H / 2);
            ps2c = 1'b0;
            wait_cyc(H);
            ps2c = 1'b1;
            if (glt && i == 4) begin
                wait_cyc(6);
                glitch();
                wait_cyc(H / 2 - 9);
            end else begin
                wait_cyc(H / 2);
            end
        end
        ps2d = 1'b1;
        wait_cyc(H);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rx_byte"}, 32'(rx_byte), 32'(e_rxb));
        check({tag, ".char"}, 32'(character), 32'(e_ch));
        check({tag, ".n_strobe"}, m_s, e_s);
        check({tag, ".n_err"}, m_e, e_e);
        check({tag, ".n_cv"}, m_cv, e_cv);
    endtask

    task automatic frame(input string tag, input logic [7:0] b,
                         input bit bad_par, input bit bad_stop,
                         input bit glt);
        send(b, bad_par, bad_stop, 11, glt);
        model_byte(b, !bad_par && !bad_stop);
        wait_cyc(10);
        check_all(tag);
    endtask

    initial begin
        logic [7:0] pool [5];
        logic [7:0] b;
        bit bp, bs;
        pool[0] = 8'hF0; pool[1] = 8'hE0; pool[2] = 8'h1C;
        pool[3] = 8'h32; pool[4] = 8'h5A;

        wait_cyc(5);
        check("rst.char", 32'(character), 0);
        check("rst.rx_byte", 32'(rx_byte), 0);
        check("rst.pulses", {29'd0, rx_strobe, frame_err, char_valid}, 0);
        rst_n = 1'b1;
        wait_cyc(20);

        frame("make_1c", 8'h1C, 0, 0, 0);
        frame("brk_f0", 8'hF0, 0, 0, 0);
        frame("brk_1c", 8'h1C, 0, 0, 0);
        frame("par_err", 8'h1C, 1, 0, 0);
        frame("make_1c_b", 8'h1C, 0, 0, 0);
        frame("rpt_1c", 8'h1C, 0, 0, 0);
        frame("brk2_f0", 8'hF0, 0, 0, 0);
        frame("stop_err", 8'h1C, 0, 1, 0);
        frame("brk2_1c", 8'h1C, 0, 0, 0);

        send(8'hA5, 0, 0, 6, 0);
        wait_cyc(TMO + 300);
        e_e++;
        check("timeout.n_err", m_e, e_e);
        check("timeout.n_strobe", m_s, e_s);
        frame("post_tmo_32", 8'h32, 0, 0, 0);

        glitch();
        wait_cyc(H);
        glitch();
        wait_cyc(H);
        frame("glitch_5a", 8'h5A, 0, 0, 1);
        frame("e0", 8'hE0, 0, 0, 0);
        frame("e0_5a", 8'h5A, 0, 0, 0);

        send(8'h1C, 0, 0, 5, 0);
        rst_n = 1'b0;
        e_ch = 8'h00; e_rxb = 8'h00; e_brk = 0;
        wait_cyc(3);
        check("midrst.char", 32'(character), 0);
        check("midrst.rx_byte", 32'(rx_byte), 0);
        check("midrst.pulses",
              {29'd0, rx_strobe, frame_err, char_valid}, 0);
        rst_n = 1'b1;
        wait_cyc(20);
        frame("post_rst_1c", 8'h1C, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(1, 255));
            else b = pool[$urandom_range(0, 4)];
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 9) == 0);
            frame($sformatf("rnd%0d", i), b, bp, bs, $urandom_range(0, 3) == 0);
        end

        check("no_back_to_back", bad_consec, 0);
        check("cv_lag", bad_lag, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter: FILTER_LEN, 8, consecutive identical synchronized samples required before the filtered ps2clk level changes.
REQ-002 Parameter: TIMEOUT_CYCLES, 200000, clk_100MHz cycles without a PS/2 falling edge before an open frame is abandoned (2 ms).
REQ-003 clk_100MHz  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 ps2clk  input  1  raw PS/2 clock from the keyboard, asynchronous, idle high.
REQ-006 ps2data  input  1  raw PS/2 data from the keyboard, asynchronous, idle high.
REQ-007 character  output  8  held scan code of the currently pressed key; 0x00 = no key.
REQ-008 char_valid  output  1  one-cycle pulse whenever character changes value.
REQ-009 rx_byte  output  8  last correctly received PS/2 byte.
REQ-010 rx_strobe  output  1  one-cycle pulse when rx_byte is updated.
REQ-011 frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Function
REQ-012 ps2clk and ps2data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-013 Filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples of the new level; shorter glitches SHALL be ignored.
REQ-014 A bit event SHALL be the cycle in which filtered clock goes 1->0; the bit value SHALL be the synchronized ps2data in that cycle.
REQ-015 Receive FSM states: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: bit event with data 0 -> DATA with bit count 0; bit event with data 1 -> stay IDLE, no output.
REQ-017 DATA: each bit event shifts data in LSB first; after the 8th bit -> PARITY.
REQ-018 PARITY: bit event stores the parity bit -> STOP.
REQ-019 STOP: on bit event, if stop bit = 1 and data plus parity has odd ones count, rx_byte SHALL load the byte and rx_strobe SHALL pulse in the next cycle; otherwise frame_err SHALL pulse in the next cycle and rx_byte SHALL remain unchanged; FSM -> IDLE in both cases.
REQ-020 Timeout counter SHALL clear on every bit event and in IDLE; in DATA/PARITY/STOP, reaching TIMEOUT_CYCLES SHALL force IDLE, pulse frame_err once, and emit no byte.
REQ-021 Decoder acts on rx_strobe; character and char_valid SHALL update one cycle after rx_strobe (two cycles after the stop-bit event).
REQ-022 Byte 0xF0: set break_pending; character unchanged; no char_valid.
REQ-023 Byte 0xE0: ignored; break_pending and character unchanged.
REQ-024 Other byte with break_pending = 1: clear break_pending; if the byte equals character, character <- 0x00 with char_valid pulse; else character unchanged.
REQ-025 Other byte with break_pending = 0: if the byte differs from character, character <- byte with char_valid pulse; if equal (typematic repeat), no char_valid.
REQ-026 frame_err SHALL NOT clear break_pending or change character.
REQ-027 rx_strobe, frame_err and char_valid SHALL never be high for more than one consecutive cycle.

Reset
REQ-028 While reset = 0: character = 0x00, rx_byte = 0x00, char_valid = rx_strobe = frame_err = 0, FSM = IDLE, break_pending = 0, counters = 0, synchronizer and filter flops = 1.
REQ-029 Reset mid-frame SHALL discard the partial frame; the first complete frame after release SHALL decode normally.

Verification
REQ-030 Frame 0x1C, parity 0, stop 1, 12.5 kHz PS/2 clock -> rx_byte = 0x1C, rx_strobe 1 cycle, then character = 0x1C and char_valid 1 cycle.
REQ-031 Frames 0x1C, 0xF0, 0x1C -> character 0x1C, then 0x00; char_valid pulses exactly twice.
REQ-032 Frame 0x1C with parity bit 1 -> frame_err 1 cycle, no rx_strobe, character unchanged.
REQ-033 Start bit plus 5 data bits, then idle 2.5 ms -> single frame_err pulse, FSM IDLE; next valid 0x32 frame -> character = 0x32.
REQ-034 ps2clk low glitches of 3 cycles injected during idle and mid-frame -> no extra bit events; frame still decodes correctly.
REQ-035 reset pulsed low after the 4th data bit -> all outputs 0x00/0; following 0x1C frame -> character = 0x1C.
